// File: rtl/dice_roller.sv
`default_nettype none
// ============================================================================
// Module   : dice_roller
// Purpose  : Galois-LFSR multi-die roller with rejection-sampled uniform faces.
// Revision : 1.0 - initial release
// ============================================================================
module dice_roller #(
    parameter int              WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS    = 16'hB400,
    parameter logic [WIDTH-1:0] SEED    = 16'hACE1,
    parameter int              MAX_DICE = 8,
    parameter int              SUM_W    = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        roll_req,
    input  logic [2:0]                  die_sel,
    input  logic [$clog2(MAX_DICE)-1:0] dice_cnt,
    input  logic                        seed_load,
    input  logic [WIDTH-1:0]            seed_in,
    output logic                        busy,
    output logic                        done,
    output logic [SUM_W-1:0]            total,
    output logic [6:0]                  last_roll
);

    localparam int CNT_W = $clog2(MAX_DICE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_step;
    logic [1:0]       r_state;
    logic [2:0]       r_die;
    logic [CNT_W-1:0] r_remaining;
    logic [6:0]       w_mask;
    logic [6:0]       w_sides;
    logic [6:0]       w_cand;
    logic [6:0]       w_face;
    logic             w_accept;

    assign w_step = {1'b0, r_lfsr[WIDTH-1:1]} ^ (r_lfsr[0] ? TAPS : '0);

    // A zero register would lock up the LFSR, so it is forced back to SEED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else if (seed_load) begin
            r_lfsr <= (seed_in == '0) ? SEED : seed_in;
        end else if (r_lfsr == '0) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= w_step;
        end
    end

    always_comb begin
        w_mask  = 7'h7F;
        w_sides = 7'd100;
        case (r_die)
            3'd0:    begin w_mask = 7'h01; w_sides = 7'd2;   end
            3'd1:    begin w_mask = 7'h03; w_sides = 7'd4;   end
            3'd2:    begin w_mask = 7'h07; w_sides = 7'd6;   end
            3'd3:    begin w_mask = 7'h07; w_sides = 7'd8;   end
            3'd4:    begin w_mask = 7'h0F; w_sides = 7'd10;  end
            3'd5:    begin w_mask = 7'h0F; w_sides = 7'd12;  end
            3'd6:    begin w_mask = 7'h1F; w_sides = 7'd20;  end
            default: begin w_mask = 7'h7F; w_sides = 7'd100; end
        endcase
    end

    // Out-of-range candidates are discarded rather than folded, keeping faces exactly uniform.
    assign w_cand   = r_lfsr[6:0] & w_mask;
    assign w_accept = (w_cand < w_sides);
    assign w_face   = w_cand + 7'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_die       <= 3'd0;
            r_remaining <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            total       <= '0;
            last_roll   <= 7'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (roll_req) begin
                        r_die       <= die_sel;
                        r_remaining <= dice_cnt;
                        total       <= '0;
                        busy        <= 1'b1;
                        r_state     <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (w_accept) begin
                        total     <= total + {{(SUM_W-7){1'b0}}, w_face};
                        last_roll <= w_face;
                        if (r_remaining == '0) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_remaining <= r_remaining - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dice_roller.sv
`default_nettype none
// Self-checking bench for dice_roller: directed scenarios with a bench-side LFSR model.
`timescale 1ns/1ps
module tb_dice_roller;

    logic        clk = 1'b0;
    logic        reset;
    logic        roll_req;
    logic [2:0]  die_sel;
    logic [2:0]  dice_cnt;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        busy;
    logic        done;
    logic [9:0]  total;
    logic [6:0]  last_roll;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    logic [9:0]  r_obs_total;
    logic [9:0]  r_exp_total;
    logic [6:0]  r_exp_last;
    bit          r_ok;
    int          r_ferr;
    int          r_cycles;
    int          r_dones;
    logic [15:0] r_seed_lfsr;
    int          hist [0:127];

    always #5 clk = ~clk;

    dice_roller dut (
        .clk       (clk),
        .reset     (reset),
        .roll_req  (roll_req),
        .die_sel   (die_sel),
        .dice_cnt  (dice_cnt),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .busy      (busy),
        .done      (done),
        .total     (total),
        .last_roll (last_roll)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [6:0] mask_of(input logic [2:0] d);
        case (d)
            3'd0: return 7'h01;  3'd1: return 7'h03;
            3'd2: return 7'h07;  3'd3: return 7'h07;
            3'd4: return 7'h0F;  3'd5: return 7'h0F;
            3'd6: return 7'h1F;  default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] sides_of(input logic [2:0] d);
        case (d)
            3'd0: return 7'd2;   3'd1: return 7'd4;
            3'd2: return 7'd6;   3'd3: return 7'd8;
            3'd4: return 7'd10;  3'd5: return 7'd12;
            3'd6: return 7'd20;  default: return 7'd100;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset)                m_lfsr <= 16'hACE1;
        else if (seed_load)       m_lfsr <= (seed_in == 16'h0) ? 16'hACE1 : seed_in;
        else if (m_lfsr == 16'h0) m_lfsr <= 16'hACE1;
        else                      m_lfsr <= lfsr_step(m_lfsr);
    end

    // Runs one request from IDLE (called on a falling edge), predicting every draw from m_lfsr.
    task automatic do_roll(input logic [2:0] die, input logic [2:0] cnt, input bit mid_req,
                           input int seed_cyc, input logic [15:0] seed_val);
        logic [6:0] c;
        bit         acc_now;
        int         acc;
        roll_req = 1'b1; die_sel = die; dice_cnt = cnt;
        @(negedge clk);
        roll_req = 1'b0; die_sel = ~die; dice_cnt = ~cnt;
        r_ok = 1'b1; r_ferr = 0; r_exp_total = 10'd0; r_exp_last = 7'd0;
        r_cycles = 0; r_dones = 0; acc = 0;
        for (int cyc = 0; cyc < 400 && acc <= int'(cnt); cyc++) begin
            if (busy !== 1'b1 || done !== 1'b0) r_ok = 1'b0;
            if (mid_req) roll_req = cyc[0];
            seed_load = (cyc == seed_cyc);
            seed_in   = seed_val;
            c       = m_lfsr[6:0] & mask_of(die);
            acc_now = (c < sides_of(die));
            @(negedge clk);
            seed_load = 1'b0;
            if (cyc == seed_cyc) r_seed_lfsr = dut.r_lfsr;
            r_cycles++;
            if (acc_now) begin
                acc++;
                r_exp_total = r_exp_total + 10'(c) + 10'd1;
                r_exp_last  = c + 7'd1;
                if (last_roll !== c + 7'd1) r_ferr++;
                if (!$isunknown(last_roll)) hist[last_roll]++;
            end
        end
        roll_req = 1'b0;
        if (acc <= int'(cnt) || done !== 1'b1 || busy !== 1'b0) r_ok = 1'b0;
        r_obs_total = total;
        if (done === 1'b1) r_dones++;
        @(negedge clk);
        if (done === 1'b1) r_dones++;
        if (mid_req) begin
            repeat (6) begin
                @(negedge clk);
                if (done === 1'b1) r_dones++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || total !== 10'd0 || last_roll !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b total=%0d last=%0d, required all 0",
                     busy, done, total, last_roll);
        end
        checks++;
        if (dut.r_lfsr !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_lfsr: got %h, required ace1", dut.r_lfsr);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.r_lfsr !== 16'hE270) begin
            errors++;
            $display("FAIL lfsr_step1: got %h, required e270", dut.r_lfsr);
        end
        @(negedge clk);
        checks++;
        if (dut.r_lfsr !== 16'h7138) begin
            errors++;
            $display("FAIL lfsr_step2: got %h, required 7138", dut.r_lfsr);
        end
    endtask

    task automatic test_single_d8();
        do_roll(3'd3, 3'd0, 1'b0, -1, 16'h0);
        checks++;
        if (r_cycles !== 1 || !r_ok) begin
            errors++;
            $display("FAIL d8_latency: draw cycles %0d ok=%0b, required 1 and ok", r_cycles, r_ok);
        end
        checks++;
        if (last_roll !== r_exp_last) begin
            errors++;
            $display("FAIL d8_face: got %0d, required %0d", last_roll, r_exp_last);
        end
        checks++;
        if (r_obs_total !== 10'(r_exp_last)) begin
            errors++;
            $display("FAIL d8_total: got %0d, required %0d", r_obs_total, r_exp_last);
        end
    endtask

    task automatic test_multi_d100();
        do_roll(3'd7, 3'd7, 1'b1, -1, 16'h0);
        checks++;
        if (r_obs_total !== r_exp_total || r_ferr != 0) begin
            errors++;
            $display("FAIL d100x8_total: got %0d (face errs %0d), required %0d",
                     r_obs_total, r_ferr, r_exp_total);
        end
        checks++;
        if (r_obs_total < 10'd8 || r_obs_total > 10'd800) begin
            errors++;
            $display("FAIL d100x8_range: got %0d, required 8..800", r_obs_total);
        end
        checks++;
        if (!r_ok) begin
            errors++;
            $display("FAIL d100x8_busy: busy/done sequencing wrong, required busy high until done");
        end
        checks++;
        if (r_dones != 1) begin
            errors++;
            $display("FAIL d100x8_done_count: got %0d done pulses, required 1", r_dones);
        end
    endtask

    task automatic test_distribution(input logic [2:0] die, input int lo, input int hi);
        int bad_total;
        int bad_ok;
        int nsides;
        int illegal;
        for (int i = 0; i < 128; i++) hist[i] = 0;
        bad_total = 0; bad_ok = 0;
        nsides = int'(sides_of(die));
        for (int r = 0; r < 750; r++) begin
            do_roll(die, 3'd7, 1'b0, -1, 16'h0);
            if (r_obs_total !== r_exp_total || r_ferr != 0) bad_total++;
            if (!r_ok) bad_ok++;
        end
        checks++;
        if (bad_total != 0 || bad_ok != 0) begin
            errors++;
            $display("FAIL dist_d%0d_model: %0d total errs, %0d seq errs, required 0", nsides, bad_total, bad_ok);
        end
        illegal = hist[0];
        for (int f = nsides + 1; f < 128; f++) illegal += hist[f];
        checks++;
        if (illegal != 0) begin
            errors++;
            $display("FAIL dist_d%0d_illegal: %0d out-of-range faces, required 0", nsides, illegal);
        end
        for (int f = 1; f <= nsides; f++) begin
            checks++;
            if (hist[f] < lo || hist[f] > hi) begin
                errors++;
                $display("FAIL dist_d%0d_face%0d: count %0d, required %0d..%0d", nsides, f, hist[f], lo, hi);
            end
        end
    endtask

    task automatic test_seed_load();
        logic [9:0] seq_a [0:2];
        logic [9:0] seq_b [0:2];
        do_roll(3'd5, 3'd3, 1'b0, 2, 16'h0000);
        checks++;
        if (r_seed_lfsr !== 16'hACE1) begin
            errors++;
            $display("FAIL seed_zero_fallback: lfsr %h, required ace1", r_seed_lfsr);
        end
        checks++;
        if (!r_ok || r_obs_total !== r_exp_total || r_obs_total < 10'd4 || r_obs_total > 10'd48) begin
            errors++;
            $display("FAIL seed_midroll_total: got %0d ok=%0b, required %0d in 4..48",
                     r_obs_total, r_ok, r_exp_total);
        end
        for (int pass = 0; pass < 2; pass++) begin
            seed_load = 1'b1; seed_in = 16'h1234;
            @(negedge clk);
            seed_load = 1'b0;
            for (int k = 0; k < 3; k++) begin
                do_roll(3'd6, 3'd2, 1'b0, -1, 16'h0);
                if (pass == 0) seq_a[k] = r_obs_total;
                else           seq_b[k] = r_obs_total;
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (seq_b[k] !== seq_a[k]) begin
                errors++;
                $display("FAIL seed_repeat_%0d: got %0d, required %0d", k, seq_b[k], seq_a[k]);
            end
        end
    endtask

    task automatic test_reset_mid_roll();
        int spurious;
        roll_req = 1'b1; die_sel = 3'd5; dice_cnt = 3'd3;
        @(negedge clk);
        roll_req = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || total !== 10'd0 || last_roll !== 7'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b total=%0d last=%0d, required all 0",
                     busy, done, total, last_roll);
        end
        @(negedge clk);
        reset = 1'b0;
        spurious = 0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL reset_abort: %0d cycles with busy/done after reset, required 0", spurious);
        end
        do_roll(3'd5, 3'd3, 1'b0, -1, 16'h0);
        checks++;
        if (!r_ok || r_obs_total !== r_exp_total) begin
            errors++;
            $display("FAIL reset_fresh_roll: got %0d ok=%0b, required %0d", r_obs_total, r_ok, r_exp_total);
        end
    endtask

    task automatic test_back_to_back();
        int  dones;
        int  bad;
        logic prev;
        dones = 0; bad = 0; prev = 1'b0;
        roll_req = 1'b1; die_sel = 3'd1; dice_cnt = 3'd0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (prev || total < 10'd1 || total > 10'd4 || total !== 10'(last_roll)) bad++;
            end
            prev = done;
        end
        roll_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dones < 9 || dones > 15 || bad != 0) begin
            errors++;
            $display("FAIL back_to_back: %0d dones, %0d bad, required 9..15 dones and 0 bad", dones, bad);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; roll_req = 1'b0; die_sel = 3'd0; dice_cnt = 3'd0;
        seed_load = 1'b0; seed_in = 16'h0;
        for (int i = 0; i < 128; i++) hist[i] = 0;
        test_reset();
        test_single_d8();
        test_multi_d100();
        test_distribution(3'd2, 850, 1150);
        test_distribution(3'd6, 220, 380);
        test_distribution(3'd4, 480, 720);
        test_seed_load();
        test_reset_mid_roll();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
